// File: rtl/syn_fifo_fwft.sv
// rtl/syn_fifo_fwft.sv - single-clock FIFO with optional first-word-fall-through read
// Registered flags/count; FWFT mode adds a one-word prefetch stage counted in O_count.
module syn_fifo_fwft #(
  parameter string MEM_STYLE = "block",
  parameter int    ASIZE     = 4,
  parameter int    DSIZE     = 8,
  parameter int    FWFT      = 0,
  parameter int    AFULL_TH  = (1 << ASIZE) - 2,
  parameter int    AEMPTY_TH = 1
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_winc,
  input  logic [DSIZE-1:0] I_wdata,
  output logic             O_wfull,
  output logic             O_afull,
  output logic             O_overflow,
  input  logic             I_rinc,
  output logic [DSIZE-1:0] O_rdata,
  output logic             O_rempty,
  output logic             O_aempty,
  output logic             O_underflow,
  output logic [ASIZE:0]   O_count
);

  localparam int             DEPTH      = 1 << ASIZE;
  localparam logic [ASIZE:0] LP_DEPTH   = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] LP_AFULL   = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] LP_AEMPTY  = (ASIZE+1)'(AEMPTY_TH);
  localparam logic [ASIZE:0] LP_ONE     = (ASIZE+1)'(1);

  logic [ASIZE:0]   r_wptr;
  logic [ASIZE:0]   r_rptr;
  logic [ASIZE:0]   r_count;
  logic             r_wfull;
  logic             r_afull;
  logic             r_aempty;
  logic             r_rempty;
  logic             r_overflow;
  logic             r_underflow;
  logic [DSIZE-1:0] r_rdata;

  logic             w_wacc;
  logic             w_racc;
  logic [ASIZE:0]   w_count_next;
  logic [DSIZE-1:0] w_ram_rdata;

  assign w_wacc       = I_winc & ~r_wfull;
  assign w_racc       = I_rinc & ~r_rempty;
  assign w_count_next = r_count + (ASIZE+1)'(w_wacc) - (ASIZE+1)'(w_racc);

  generate
    if (MEM_STYLE == "distributed") begin : g_dist_ram
      (* ram_style = "distributed" *) logic [DSIZE-1:0] r_mem [DEPTH];
      always_ff @(posedge I_clk) begin
        if (w_wacc) r_mem[r_wptr[ASIZE-1:0]] <= I_wdata;
      end
      assign w_ram_rdata = r_mem[r_rptr[ASIZE-1:0]];
    end else begin : g_block_ram
      (* ram_style = "block" *) logic [DSIZE-1:0] r_mem [DEPTH];
      always_ff @(posedge I_clk) begin
        if (w_wacc) r_mem[r_wptr[ASIZE-1:0]] <= I_wdata;
      end
      assign w_ram_rdata = r_mem[r_rptr[ASIZE-1:0]];
    end
  endgenerate

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_wptr      <= '0;
      r_count     <= '0;
      r_wfull     <= 1'b0;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wacc) r_wptr <= r_wptr + LP_ONE;
      r_count     <= w_count_next;
      r_wfull     <= (w_count_next == LP_DEPTH);
      r_afull     <= (w_count_next >= LP_AFULL);
      r_aempty    <= (w_count_next <= LP_AEMPTY);
      r_overflow  <= I_winc & r_wfull;
      r_underflow <= I_rinc & r_rempty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Refill the output stage whenever it is free or being popped and RAM holds data.
      logic w_fetch;
      assign w_fetch = (r_wptr != r_rptr) & (r_rempty | w_racc);
      always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
          r_rptr   <= '0;
          r_rdata  <= '0;
          r_rempty <= 1'b1;
        end else if (w_fetch) begin
          r_rdata  <= w_ram_rdata;
          r_rptr   <= r_rptr + LP_ONE;
          r_rempty <= 1'b0;
        end else if (w_racc) begin
          r_rempty <= 1'b1;
        end
      end
    end else begin : g_std
      always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
          r_rptr   <= '0;
          r_rdata  <= '0;
          r_rempty <= 1'b1;
        end else begin
          if (w_racc) begin
            r_rdata <= w_ram_rdata;
            r_rptr  <= r_rptr + LP_ONE;
          end
          r_rempty <= (w_count_next == '0);
        end
      end
    end
  endgenerate

  assign O_wfull     = r_wfull;
  assign O_afull     = r_afull;
  assign O_overflow  = r_overflow;
  assign O_rdata     = r_rdata;
  assign O_rempty    = r_rempty;
  assign O_aempty    = r_aempty;
  assign O_underflow = r_underflow;
  assign O_count     = r_count;

endmodule

// File: tb/tb_syn_fifo_fwft.sv
// tb/tb_syn_fifo_fwft.sv - scoreboard bench for syn_fifo_fwft in standard and FWFT modes
module tb_syn_fifo_fwft;

  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 14;
  localparam int AEMPTY_TH = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic       rinc;
  logic [7:0] wdata;

  logic       s_wfull, s_afull, s_ovf, s_rempty, s_aempty, s_udf;
  logic [7:0] s_rdata;
  logic [4:0] s_count;
  logic       f_wfull, f_afull, f_ovf, f_rempty, f_aempty, f_udf;
  logic [7:0] f_rdata;
  logic [4:0] f_count;

  int q_data [2][$];
  int q_cyc  [2][$];
  bit exp_ovf [2];
  bit exp_udf [2];
  int exp_rd  [2];
  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  syn_fifo_fwft #(.MEM_STYLE("block"), .ASIZE(4), .DSIZE(8), .FWFT(0),
                  .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)) u_std (
    .I_clk(clk), .I_rst(rst), .I_winc(winc), .I_wdata(wdata),
    .O_wfull(s_wfull), .O_afull(s_afull), .O_overflow(s_ovf),
    .I_rinc(rinc), .O_rdata(s_rdata), .O_rempty(s_rempty),
    .O_aempty(s_aempty), .O_underflow(s_udf), .O_count(s_count)
  );

  syn_fifo_fwft #(.MEM_STYLE("distributed"), .ASIZE(4), .DSIZE(8), .FWFT(1),
                  .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)) u_fwft (
    .I_clk(clk), .I_rst(rst), .I_winc(winc), .I_wdata(wdata),
    .O_wfull(f_wfull), .O_afull(f_afull), .O_overflow(f_ovf),
    .I_rinc(rinc), .O_rdata(f_rdata), .O_rempty(f_rempty),
    .O_aempty(f_aempty), .O_underflow(f_udf), .O_count(f_count)
  );

  task automatic chk(input string name, input int m, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s mode%0d cyc %0d: got %0d expected %0d", name, m, cyc, act, exp);
    end
  endtask

  // Reference model: contents as a queue; in FWFT mode a word is visible two cycles after its write.
  task automatic model_step(input int m, input int a_cnt, input int a_wfull, input int a_afull,
                            input int a_aempty, input int a_rempty, input int a_ovf,
                            input int a_udf, input int a_rd);
    int n;
    bit e_wfull, e_rempty, wacc, racc;
    if (rst) begin
      q_data[m].delete();
      q_cyc[m].delete();
      exp_ovf[m] = 1'b0;
      exp_udf[m] = 1'b0;
      exp_rd[m]  = 0;
      chk("rst_count", m, a_cnt, 0);
      chk("rst_rempty", m, a_rempty, 1);
      chk("rst_aempty", m, a_aempty, 1);
      chk("rst_wfull", m, a_wfull, 0);
      chk("rst_rdata", m, a_rd, 0);
      return;
    end
    n = q_data[m].size();
    e_wfull = (n == DEPTH);
    if (m == 0) e_rempty = (n == 0);
    else        e_rempty = !(n > 0 && q_cyc[m][0] <= cyc - 2);
    chk("count", m, a_cnt, n);
    chk("wfull", m, a_wfull, int'(e_wfull));
    chk("afull", m, a_afull, int'(n >= AFULL_TH));
    chk("aempty", m, a_aempty, int'(n <= AEMPTY_TH));
    chk("rempty", m, a_rempty, int'(e_rempty));
    chk("overflow", m, a_ovf, int'(exp_ovf[m]));
    chk("underflow", m, a_udf, int'(exp_udf[m]));
    if (m == 0)         chk("rdata", m, a_rd, exp_rd[m]);
    else if (!e_rempty) chk("rdata", m, a_rd, q_data[m][0]);
    wacc = winc && !e_wfull;
    racc = rinc && !e_rempty;
    exp_ovf[m] = winc && e_wfull;
    exp_udf[m] = rinc && e_rempty;
    if (racc) begin
      exp_rd[m] = q_data[m].pop_front();
      void'(q_cyc[m].pop_front());
    end
    if (wacc) begin
      q_data[m].push_back(int'(wdata));
      q_cyc[m].push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    model_step(0, int'(s_count), int'(s_wfull), int'(s_afull), int'(s_aempty),
               int'(s_rempty), int'(s_ovf), int'(s_udf), int'(s_rdata));
    model_step(1, int'(f_count), int'(f_wfull), int'(f_afull), int'(f_aempty),
               int'(f_rempty), int'(f_ovf), int'(f_udf), int'(f_rdata));
    cyc++;
  end

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // asynchronous reset in the middle of a write burst
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h30 + i));
    chk("pre_rst_count", 0, int'(s_count), 5);
    chk("pre_rst_count", 1, int'(f_count), 5);
    chk("pre_rst_rdata", 1, int'(f_rdata), 8'h30);
    rst = 1'b1;
    #1;
    chk("async_count", 0, int'(s_count), 0);
    chk("async_count", 1, int'(f_count), 0);
    chk("async_rempty", 0, int'(s_rempty), 1);
    chk("async_rempty", 1, int'(f_rempty), 1);
    chk("async_rdata", 1, int'(f_rdata), 0);
    chk("async_aempty", 1, int'(f_aempty), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);

    // fill to full, one rejected write, then simultaneous request at full
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(i));
    drive(1'b1, 1'b0, 8'hEE);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // simultaneous request at empty, then single-word latency
    drive(1'b1, 1'b1, 8'hA5);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // back-to-back pops of 8 words
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(8'h40 + i));
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // random traffic biased toward filling, balanced, then draining
    for (int i = 0; i < 300; i++) begin
      int pw;
      pw = (i < 100) ? 70 : ((i < 200) ? 50 : 30);
      drive(logic'($urandom_range(0, 99) < pw), logic'($urandom_range(0, 99) < (100 - pw)),
            8'($urandom));
    end
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
